// File: rtl/operand_skew_feeder.sv
// rtl/operand_skew_feeder.sv - buffers one operand tile and feeds it diagonally skewed into the PE array edge
module operand_skew_feeder #(
  parameter int SYS_ARRAY_SIZE = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int K_LEN          = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic                                     vec_valid_i,
  output logic                                     vec_ready_o,
  input  logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0]     vec_data_i,
  input  logic                                     advance_i,
  output logic [SYS_ARRAY_SIZE-1:0][DATA_WIDTH:0]  out_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int N    = SYS_ARRAY_SIZE;
  localparam int WP_W = $clog2(K_LEN + 1);
  localparam int T_W  = $clog2(K_LEN + N);

  localparam logic [WP_W-1:0] LAST_WR = WP_W'(K_LEN - 1);
  localparam logic [T_W-1:0]  LAST_T  = T_W'(K_LEN + N - 2);

  // Each lane is {last, data}; out_o carries the same packed layout.
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } matrix_data_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED
  } state_t;

  state_t                state;
  logic [WP_W-1:0]       wr_ptr;
  logic [T_W-1:0]        t;
  matrix_data_t [N-1:0]  out_q;
  matrix_data_t [N-1:0]  lane_next;
  logic [DATA_WIDTH-1:0] vec_buf [K_LEN][N];

  assign vec_ready_o = (state == LOAD);
  assign busy_o      = (state != IDLE);
  assign out_o       = out_q;

  // Lane i at step t shows element t-i of the tile, or a bubble when t-i is outside the tile.
  always_comb begin
    lane_next = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K_LEN; k++) begin
        if (t == T_W'(k + i)) begin
          lane_next[i].data = vec_buf[k][i];
          lane_next[i].last = (k == K_LEN - 1);
        end
      end
    end
  end

  // Tile storage; deliberately not reset, every slot is written before FEED reads it.
  always_ff @(posedge clk) begin
    if (state == LOAD && vec_valid_i) begin
      for (int k = 0; k < K_LEN; k++) begin
        if (wr_ptr == WP_W'(k)) begin
          for (int i = 0; i < N; i++) begin
            vec_buf[k][i] <= vec_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Control FSM: IDLE waits for start, LOAD fills the buffer, FEED steps the skew on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      t      <= '0;
      out_q  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          out_q <= '0;
          if (start_i) begin
            state  <= LOAD;
            wr_ptr <= '0;
            t      <= '0;
          end
        end
        LOAD: begin
          out_q <= '0;
          if (vec_valid_i) begin
            wr_ptr <= wr_ptr + WP_W'(1);
            if (wr_ptr == LAST_WR) begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (advance_i) begin
            out_q <= lane_next;
            t     <= t + T_W'(1);
            if (t == LAST_T) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          out_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb/tb_operand_skew_feeder.sv - randomized self-checking bench for operand_skew_feeder
module tb_operand_skew_feeder;

  localparam int NL    = 2;
  localparam int KL    = 4;
  localparam int DW    = 8;
  localparam int STEPS = KL + NL - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic               vec_valid_i = 1'b0;
  logic               vec_ready_o;
  logic [NL*DW-1:0]   vec_data_i = '0;
  logic               advance_i = 1'b0;
  logic [NL-1:0][DW:0] out_o;
  logic               busy_o;
  logic               done_o;

  logic               start1 = 1'b0;
  logic               valid1 = 1'b0;
  logic               ready1;
  logic [NL*DW-1:0]   data1 = '0;
  logic               advance1 = 1'b0;
  logic [NL-1:0][DW:0] out1;
  logic               busy1;
  logic               done1;

  int n_checks = 0;
  int n_err    = 0;

  operand_skew_feeder #(.SYS_ARRAY_SIZE(NL), .DATA_WIDTH(DW), .K_LEN(KL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vec_valid_i(vec_valid_i),
    .vec_ready_o(vec_ready_o), .vec_data_i(vec_data_i), .advance_i(advance_i),
    .out_o(out_o), .busy_o(busy_o), .done_o(done_o)
  );

  operand_skew_feeder #(.SYS_ARRAY_SIZE(NL), .DATA_WIDTH(DW), .K_LEN(1)) dut_k1 (
    .clk(clk), .rst(rst), .start_i(start1), .vec_valid_i(valid1),
    .vec_ready_o(ready1), .vec_data_i(data1), .advance_i(advance1),
    .out_o(out1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One tile on the K_LEN=4 instance. gap_mode: 0 none, 1 three-cycle gap before v2, 2 random.
  // stall_mode: 0 none, 1 two-cycle stall at t=2, 2 random. abort_at >= 0 resets at that step.
  task automatic run_tile(input int gap_mode, input int stall_mode, input bit spurious,
                          input bit directed, input int abort_at);
    logic [DW-1:0] v [KL][NL];
    logic [DW:0]   exp_lane [STEPS][NL];
    logic [DW:0]   hold [NL];
    int loaded, gaps, load_cycles, s, stalls, feed_cycles, gapped, stalled;
    bit want, adv;

    for (int j = 0; j < KL; j++) begin
      for (int i = 0; i < NL; i++) begin
        if (directed) v[j][i] = (i == 0) ? DW'(j + 1) : DW'(8'h10 + j);
        else          v[j][i] = DW'($urandom);
      end
    end
    for (int st = 0; st < STEPS; st++) begin
      for (int i = 0; i < NL; i++) begin
        if (st - i >= 0 && st - i < KL) exp_lane[st][i] = {(st - i == KL - 1), v[st - i][i]};
        else                            exp_lane[st][i] = '0;
      end
    end

    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("ready_after_start", vec_ready_o, 1);

    loaded = 0; gaps = 0; load_cycles = 0; gapped = 0;
    while (loaded < KL && load_cycles < 200) begin
      if (gap_mode == 1)      want = !(loaded == 2 && gapped < 3);
      else if (gap_mode == 2) want = ($urandom_range(0, 2) != 0);
      else                    want = 1'b1;
      if (!want) begin gaps++; gapped++; end
      vec_valid_i = want;
      vec_data_i  = want ? {v[loaded][1], v[loaded][0]} : {$urandom}[NL*DW-1:0];
      if (spurious && loaded == 1) start_i = 1'b1;
      @(posedge clk); #1;
      load_cycles++;
      if (want) loaded++;
      vec_valid_i = 1'b0;
      start_i = 1'b0;
      check("ready_load", vec_ready_o, (loaded < KL));
      check("out_zero_load", out_o, 0);
    end
    check("load_cycles", load_cycles, KL + gaps);
    if (gap_mode == 1) check("load_cycles_gap", load_cycles, KL + 3);

    for (int i = 0; i < NL; i++) hold[i] = '0;
    s = 0; stalls = 0; feed_cycles = 0; stalled = 0;
    while (s < STEPS && feed_cycles < 200) begin
      if (s == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_out", out_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_ready", vec_ready_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        advance_i = 1'b0;
        return;
      end
      if (stall_mode == 1)      adv = !(s == 2 && stalled < 2);
      else if (stall_mode == 2) adv = ($urandom_range(0, 3) != 0);
      else                      adv = 1'b1;
      if (!adv) begin stalls++; stalled++; end
      advance_i = adv;
      if (spurious && s == 1) start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      feed_cycles++;
      if (adv) begin
        for (int i = 0; i < NL; i++) begin
          check($sformatf("step%0d_lane%0d", s, i), out_o[i], exp_lane[s][i]);
          hold[i] = exp_lane[s][i];
        end
        check($sformatf("done_step%0d", s), done_o, (s == STEPS - 1));
        s++;
      end else begin
        for (int i = 0; i < NL; i++) check($sformatf("hold_lane%0d", i), out_o[i], hold[i]);
        check("done_stall", done_o, 0);
      end
      check("ready_feed", vec_ready_o, 0);
    end
    check("feed_cycles", feed_cycles, STEPS + stalls);
    if (stall_mode == 1) check("feed_cycles_stall", feed_cycles, 7);

    advance_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_busy", busy_o, 0);
      check("post_done", done_o, 0);
      check("post_out", out_o, 0);
      check("post_ready", vec_ready_o, 0);
    end
  endtask

  initial begin
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_ready", vec_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_out", out_o, 0);
    check("rst_k1_out", out1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy_o, 0);

    run_tile(0, 0, 0, 1, -1);   // basic skew
    run_tile(1, 0, 0, 1, -1);   // input gaps
    run_tile(0, 1, 0, 1, -1);   // advance stall
    run_tile(0, 0, 1, 1, -1);   // ignored start
    run_tile(0, 0, 0, 1, 2);    // reset mid-FEED
    run_tile(0, 0, 0, 1, -1);   // fresh tile after reset
    for (int r = 0; r < 12; r++) run_tile(2, 2, r[0], 0, -1);

    // K_LEN=1 instance
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("k1_ready", ready1, 1);
    valid1 = 1'b1;
    data1  = {8'hAA, 8'h55};
    @(posedge clk); #1;
    valid1 = 1'b0;
    check("k1_ready_feed", ready1, 0);
    advance1 = 1'b1;
    @(posedge clk); #1;
    check("k1_t0_lane0", out1[0], {1'b1, 8'h55});
    check("k1_t0_lane1", out1[1], 0);
    check("k1_t0_done", done1, 0);
    @(posedge clk); #1;
    check("k1_t1_lane0", out1[0], 0);
    check("k1_t1_lane1", out1[1], {1'b1, 8'hAA});
    check("k1_t1_done", done1, 1);
    @(posedge clk); #1;
    advance1 = 1'b0;
    check("k1_post_busy", busy1, 0);
    check("k1_post_out", out1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Edge feeder for the systolic array. It buffers one operand tile as `K_LEN` column vectors of `SYS_ARRAY_SIZE` elements, then drives them into the array's edge PEs with the diagonal skew the PE grid needs. Each lane carries a `matrix_data_t`, and the lane's `last` flag marks its final element. One instance feeds the A edge and one feeds the B edge, between the memory read path and the PE array.

## Interface
- `SYS_ARRAY_SIZE`, default 2: number of lanes N, one per PE row or column.
- `DATA_WIDTH`, default 8: element width.
- `K_LEN`, default 4: vectors per tile, the inner dimension; must be at least 1.

Ports:
- `clk`  in  1  clock; single clock domain, all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  begin a tile; sampled only in IDLE.
- `vec_valid_i`  in  1  input vector valid.
- `vec_ready_o`  out  1  feeder can accept a vector.
- `vec_data_i`  in  N*DATA_WIDTH  vector; element i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `advance_i`  in  1  array step enable; the skew advances only when it is high.
- `out_o`  out  N x `matrix_data_t`  lane i drives the edge PE of row/column i.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse when the last skew step is registered.

## Operation
The state machine has three states: IDLE, LOAD and FEED.

- **IDLE**
  - If `start_i`=1, go to LOAD and clear `wr_ptr` and `t`.
  - If `start_i`=0, stay in IDLE.
- **LOAD**
  - `vec_ready_o`=1.
  - Each handshake (`vec_valid_i`&`vec_ready_o`) writes `buf[wr_ptr]` and increments `wr_ptr`.
  - The handshake with `wr_ptr`=K_LEN-1 moves the block to FEED.
  - `advance_i` is ignored in this state.
- **FEED**
  - `vec_ready_o`=0.
  - On each cycle with `advance_i`=1, register lane i for step `t`:
    - if 0 ≤ t-i < K_LEN: `data`=`buf[t-i][i]`, `last`=(t-i==K_LEN-1);
    - otherwise: `data`=0, `last`=0 (bubble).
  - After registering, increment `t`.
  - The step with t = K_LEN+N-2 is the final step: go to IDLE and pulse `done_o` for that same cycle.
  - With `advance_i`=0, `out_o` and `t` hold.
- **Outside FEED**, every edge clears `out_o` to all-zero bubbles.
- `start_i` outside IDLE is ignored; it is not queued.
- Counter widths:
  - `wr_ptr` is $clog2(K_LEN+1) bits.
  - `t` is $clog2(K_LEN+N) bits.
  - Neither counter wraps; both are reset at IDLE→LOAD.
- The buffer holds K_LEN×N elements and is not cleared by reset. Its contents are don't-care until written.

## Timing
- **Reset values:** state IDLE; `vec_ready_o`=0, `busy_o`=0, `done_o`=0; every `out_o` lane has `data`=0 and `last`=0. The counters are zero.
- **Start:** `start_i` at edge n gives `vec_ready_o`=1 and `busy_o`=1 from cycle n+1.
- **Load:** the minimum load time is K_LEN cycles. `vec_ready_o` drops combinationally with the state on the cycle after the K_LEN-th handshake.
- **Feed:** this phase takes exactly K_LEN+N-1 cycles with `advance_i` high; stalls add cycles 1:1.
- **Lane skew:** lane i's first element appears i advance-steps after lane 0's.
- **done_o:** coincides with the registered final step, when lane N-1 shows `last`=1. `busy_o` is 0 on the next cycle.
- **Back-to-back tiles:** a new `start_i` is accepted on the first IDLE cycle after `done_o`.
- **Mid-operation reset:** asserting `rst` in any state returns the block to IDLE immediately (asynchronous). Outputs take their reset values, and the partial tile is discarded.

## Test plan
Defaults throughout are N=2, K_LEN=4.

1. **Basic skew.** Reset, pulse `start_i`, load vectors v_j = {lane1=0x10+j, lane0=j+1} for j=0..3 back-to-back, then hold `advance_i`=1. Required output over steps t=0..4:
   - Lane 0 `data`: 01, 02, 03, 04, 00; `last`=1 only at t=3.
   - Lane 1 `data`: 00, 10, 11, 12, 13; `last`=1 only at t=4.
   - `done_o`=1 at t=4 only; `out_o` is zero on the following cycle.
2. **Input gaps.** Same stimulus as scenario 1, but drop `vec_valid_i` for 3 cycles between v1 and v2. Required: no vector is lost, the FEED output is identical to scenario 1, and the block enters FEED 3 cycles later.
3. **Advance stall.** Drop `advance_i` for 2 cycles at t=2. Required: `out_o` holds the t=1 values for those 2 cycles, then continues at t=2. The total FEED time is 7 cycles.
4. **Ignored start.** Pulse `start_i` during LOAD and during FEED. Required: no effect; exactly one `done_o`, and no second tile begins.
5. **Reset mid-FEED.** Assert `rst` at t=2. Required: `out_o`=0, `busy_o`=0, `done_o`=0, `vec_ready_o`=0 immediately. A fresh tile then runs correctly, as in scenario 1.
6. **Degenerate K_LEN=1, N=2.** Load one vector {lane1=0xAA, lane0=0x55}. Required:
   - t=0: lane 0 = (0x55, `last`=1); lane 1 = bubble.
   - t=1: lane 0 = bubble; lane 1 = (0xAA, `last`=1); `done_o`=1.
